// File: rtl/fp32_pkg.sv
// Shared FP32 types, constants and accumulator state encoding.
// Used by flp_adder and fp32_dot_accumulator.
package fp32_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;
  localparam fp32_t FP32_QNAN     = 32'h7FC0_0000;
  localparam fp32_t FP32_POS_INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ACC,
    DRAIN,
    DONE
  } acc_state_e;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/flp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Handles denormals, signed zeros, infinities and NaN (quiet NaN out).
module flp_adder
  import fp32_pkg::*;
(
  input  fp32_t num1,
  input  fp32_t num2,
  output fp32_t sum
);

  logic        a_nan;
  logic        b_nan;
  logic        a_inf;
  logic        b_inf;
  logic        swap;
  fp32_t       big;
  fp32_t       sml;
  logic [9:0]  eb;
  logic [9:0]  es;
  logic [9:0]  d;
  logic [9:0]  em1;
  logic [9:0]  e;
  logic [9:0]  ef;
  logic [26:0] mb;
  logic [26:0] ms;
  logic [26:0] al;
  logic [27:0] r;
  logic [4:0]  lz;
  logic [4:0]  sh;
  logic        eff_sub;
  logic        up;
  logic [32:0] pre;
  logic [32:0] rnd;
  logic [30:0] mag;

  always_comb begin
    a_nan = (&num1[30:23]) & (|num1[22:0]);
    b_nan = (&num2[30:23]) & (|num2[22:0]);
    a_inf = (&num1[30:23]) & ~(|num1[22:0]);
    b_inf = (&num2[30:23]) & ~(|num2[22:0]);

    swap = num2[30:0] > num1[30:0];
    big  = swap ? num2 : num1;
    sml  = swap ? num1 : num2;

    // Denormals use effective exponent 1 with no hidden bit.
    eb = (big[30:23] == 8'd0) ? 10'd1 : {2'b00, big[30:23]};
    es = (sml[30:23] == 8'd0) ? 10'd1 : {2'b00, sml[30:23]};
    mb = {|big[30:23], big[22:0], 3'b000};
    ms = {|sml[30:23], sml[22:0], 3'b000};
    d  = eb - es;

    if (d >= 10'd27) begin
      al = {26'd0, |ms};
    end else begin
      al    = ms >> d[4:0];
      al[0] = al[0] | (|(ms & ~(27'h7FF_FFFF << d[4:0])));
    end

    eff_sub = big[31] ^ sml[31];
    e       = eb;
    em1     = eb - 10'd1;
    lz      = 5'd0;
    sh      = 5'd0;

    if (!eff_sub) begin
      r = {1'b0, mb} + {1'b0, al};
      if (r[27]) begin
        r = {1'b0, r[27:2], r[1] | r[0]};
        e = eb + 10'd1;
      end
    end else begin
      r  = {1'b0, mb} - {1'b0, al};
      lz = lzc27(r[26:0]);
      sh = ({5'd0, lz} <= em1) ? lz : em1[4:0];
      r  = r << sh;
      e  = eb - {5'd0, sh};
    end

    ef  = r[26] ? e : 10'd0;
    up  = r[2] & (r[1] | r[0] | r[3]);
    pre = {ef, r[25:3]};
    rnd = pre + {32'd0, up};

    if (rnd[32:23] >= 10'd255) mag = FP32_POS_INF[30:0];
    else                       mag = rnd[30:0];

    if (a_nan | b_nan | (a_inf & b_inf & (num1[31] ^ num2[31])))
      sum = FP32_QNAN;
    else if (a_inf)
      sum = num1;
    else if (b_inf)
      sum = num2;
    else if (r == 28'd0)
      sum = {big[31] & sml[31], 31'd0};
    else
      sum = {big[31], mag};
  end

endmodule

// File: rtl/fp32_dot_accumulator.sv
// Streaming FP32 dot-product accumulator feeding one flp_adder.
// Optional FP32_ACC_BIAS_EN adds a bias port used as the initial sum.
module fp32_dot_accumulator
  import fp32_pkg::*;
#(
  parameter int VEC_LEN = 784
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
`ifdef FP32_ACC_BIAS_EN
  input  logic [31:0] bias,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  acc_state_e       state;
  fp32_t            acc;
  fp32_t            op_reg;
  logic             op_vld;
  logic [CNT_W-1:0] cnt;
  fp32_t            sum;
  fp32_t            init_val;
  logic             in_hs;

`ifdef FP32_ACC_BIAS_EN
  assign init_val = bias;
`else
  assign init_val = FP32_POS_ZERO;
`endif

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign in_hs     = in_valid & in_ready;

  flp_adder u_add (
    .num1 (acc),
    .num2 (op_reg),
    .sum  (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ACC;
      acc    <= init_val;
      op_reg <= FP32_POS_ZERO;
      op_vld <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        ACC: begin
          if (op_vld) acc <= sum;
          if (in_hs) begin
            op_reg <= in_data;
            op_vld <= 1'b1;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            op_vld <= 1'b0;
          end
        end
        DRAIN: begin
          acc    <= sum;
          op_vld <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            acc   <= init_val;
            state <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_dot_accumulator.sv
// Randomized bench for fp32_dot_accumulator against a real-valued model.
// Build with FP32_ACC_BIAS_EN to exercise the bias port.
module tb_fp32_dot_accumulator;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
`ifdef FP32_ACC_BIAS_EN
  logic [31:0] bias = 32'h3F00_0000;
  real         init_r = 0.5;
`else
  real         init_r = 0.0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp32_dot_accumulator #(.VEC_LEN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef FP32_ACC_BIAS_EN
    .bias      (bias),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic real fp2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    e = int'(f[30:23]);
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    m = m * (2.0 ** real'(e - 127));
    return f[31] ? -m : m;
  endfunction

  // Exact encode for values representable as normal FP32 numbers.
  function automatic logic [31:0] r2fp(input real x);
    real  a;
    int   e;
    logic s;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  task automatic run_vec(input string tag, input logic [31:0] v[N],
                         input int mode, input int hold);
    int          i;
    int          guard;
    bit          hs;
    real         sum_r;
    logic [31:0] exp_v;
    i = 0;
    guard = 0;
    sum_r = init_r;
    for (int j = 0; j < N; j++) sum_r += fp2r(v[j]);
    exp_v = r2fp(sum_r);
    while (i < N && guard < 100) begin
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = (guard % 2 == 0);
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      in_data = in_valid ? v[i] : $urandom;
`ifdef FP32_ACC_BIAS_EN
      bias = $urandom;
`endif
      hs = in_valid && in_ready;
      step;
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0;
`ifdef FP32_ACC_BIAS_EN
    bias = 32'h3F00_0000;
`endif
    chk({tag, ":accepted"}, 32'(i), 32'(N));
    chk({tag, ":drain_ov"}, 32'(out_valid), 32'd0);
    chk({tag, ":drain_ir"}, 32'(in_ready), 32'd0);
    step;
    chk({tag, ":ov"}, 32'(out_valid), 32'd1);
    chk({tag, ":data"}, out_data, exp_v);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = $urandom;
      step;
      chk({tag, ":hold_data"}, out_data, exp_v);
      chk({tag, ":hold_ir"}, 32'(in_ready), 32'd0);
      chk({tag, ":hold_ov"}, 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step;
    chk({tag, ":rel_ov"}, 32'(out_valid), 32'd0);
    chk({tag, ":rel_ir"}, 32'(in_ready), 32'd1);
    chk({tag, ":rel_init"}, out_data, r2fp(init_r));
  endtask

  logic [31:0] v_a[N] = '{32'h3F80_0000, 32'h4000_0000,
                          32'h4040_0000, 32'h4080_0000};
  logic [31:0] v_c[N] = '{32'h3F80_0000, 32'hBF80_0000,
                          32'h3F00_0000, 32'h3F00_0000};
  logic [31:0] v_r[N];

  initial begin
    step;
    step;
    rst = 1'b0;
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, r2fp(init_r));

    run_vec("b2b", v_a, 0, 0);
    run_vec("toggle", v_a, 1, 0);
    run_vec("cancel", v_c, 0, 0);
    run_vec("hold5", v_a, 0, 5);
    run_vec("after_hold", v_c, 2, 0);

    in_valid = 1'b1;
    in_data  = 32'h3F80_0000;
    step;
    in_data  = 32'h4000_0000;
    step;
    in_valid = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst_ir", 32'(in_ready), 32'd1);
    chk("midrst_ov", 32'(out_valid), 32'd0);
    chk("midrst_data", out_data, r2fp(init_r));
    run_vec("post_rst", v_a, 0, 0);

    for (int t = 0; t < 25; t++) begin
      for (int j = 0; j < N; j++)
        v_r[j] = r2fp(real'(int'($urandom_range(0, 256)) - 128) * 0.25);
      run_vec($sformatf("rnd%0d", t), v_r, 2, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
